// File: rtl/xbus_lane_lock_pkg.sv
// rtl/xbus_lane_lock_pkg.sv - shared types and constants for the xbus lane lock detector
package xbus_lane_lock_pkg;

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED, LOSS} lane_lock_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int cnt_width(input int lock_cnt, input int unlock_cnt);
        int m;
        m = (lock_cnt > unlock_cnt) ? lock_cnt : unlock_cnt;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/xbus_lane_lock_fsm.sv
// rtl/xbus_lane_lock_fsm.sv - single-lane sync lock FSM with optional loss counter
// Optional loss statistics enabled by XBUS_LANE_LOCK_STATS_EN.
module xbus_lane_lock_fsm
    import xbus_lane_lock_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sync_i,
    input  logic                  err_i,
    input  logic                  force_hunt_i,
    input  logic                  stats_clr_i,
    output logic                  locked_o,
    output logic                  locked_d_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    lane_lock_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             locked_q, locked_d, eff_sync;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eff_sync = sync_i & ~err_i;
        cnt_inc  = cnt_q + ONE_C;
        if (force_hunt_i) begin
            state_d = HUNT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: if (eff_sync) begin
                    if (LOCK_C == ONE_C) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = ONE_C;
                    end
                end
                CONFIRM: begin
                    if (!eff_sync) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else if (cnt_inc == LOCK_C) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOCKED: if (err_i) begin
                    if (UNLOCK_C == ONE_C) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOSS;
                        cnt_d   = ONE_C;
                    end
                end
                LOSS: begin
                    if (!err_i) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else if (cnt_inc == UNLOCK_C) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED) || (state_d == LOSS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked_o   = locked_q;
    assign locked_d_o = locked_d;

`ifdef XBUS_LANE_LOCK_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // Clear takes precedence over a coincident loss event.
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            loss_q <= '0;
        end else if (locked_q && !locked_d && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_cnt_o = loss_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign loss_cnt_o       = '0;
`endif

endmodule

// File: rtl/xbus_lane_lock.sv
// rtl/xbus_lane_lock.sv - multi-lane sync lock detector with aggregate lock and change pulse
// Optional loss statistics enabled by XBUS_LANE_LOCK_STATS_EN.
module xbus_lane_lock
    import xbus_lane_lock_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LANES-1:0]            sync_i,
    input  logic [LANES-1:0]            err_i,
    input  logic [LANES-1:0]            force_hunt_i,
    input  logic                        stats_clr_i,
    output logic [LANES-1:0]            locked_o,
    output logic                        all_locked_o,
    output logic [LANES-1:0]            lock_chg_o,
    output logic [LANES*LOSS_CNT_W-1:0] loss_cnt_o
);

    localparam int CNT_W = cnt_width(LOCK_CNT, UNLOCK_CNT);

    logic [LANES-1:0] locked_w, locked_d;
    logic             all_locked_q;
    logic [LANES-1:0] lock_chg_q;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        xbus_lane_lock_fsm #(
            .LOCK_CNT  (LOCK_CNT),
            .UNLOCK_CNT(UNLOCK_CNT),
            .CNT_W     (CNT_W)
        ) u_fsm (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .sync_i      (sync_i[n]),
            .err_i       (err_i[n]),
            .force_hunt_i(force_hunt_i[n]),
            .stats_clr_i (stats_clr_i),
            .locked_o    (locked_w[n]),
            .locked_d_o  (locked_d[n]),
            .loss_cnt_o  (loss_cnt_o[n*LOSS_CNT_W +: LOSS_CNT_W])
        );
    end

    // Built from next-state lock so both flags line up with locked_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            all_locked_q <= 1'b0;
            lock_chg_q   <= '0;
        end else begin
            all_locked_q <= &locked_d;
            lock_chg_q   <= locked_d ^ locked_w;
        end
    end

    assign locked_o     = locked_w;
    assign all_locked_o = all_locked_q;
    assign lock_chg_o   = lock_chg_q;

endmodule

// File: tb/tb_xbus_lane_lock.sv
// tb/tb_xbus_lane_lock.sv - self-checking bench for xbus_lane_lock against a run-length lock model
module tb_xbus_lane_lock;

    localparam int LANES  = 4;
    localparam int LOCK   = 8;
    localparam int UNLOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sync_v = '0, err_v = '0, force_v = '0;
    logic        clr = 1'b0;
    logic [3:0]  locked, chg;
    logic        all_locked;
    logic [31:0] loss;

    int n_cmp = 0;
    int n_fail = 0;

    xbus_lane_lock #(.LANES(LANES), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sync_i      (sync_v),
        .err_i       (err_v),
        .force_hunt_i(force_v),
        .stats_clr_i (clr),
        .locked_o    (locked),
        .all_locked_o(all_locked),
        .lock_chg_o  (chg),
        .loss_cnt_o  (loss)
    );

    always #5 clk = ~clk;

    // Model: count consecutive good syncs while unlocked, consecutive errors while locked.
    int          sync_run [4];
    int          err_run  [4];
    int          loss_m   [4];
    logic [3:0]  m_locked = '0, m_chg = '0;
    logic        m_all = 1'b0;
    logic [31:0] m_loss = '0;
    bit          started = 0;

`ifdef XBUS_LANE_LOCK_STATS_EN
    localparam bit STATS = 1;
`else
    localparam bit STATS = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] prev, nxt;
        prev = m_locked;
        nxt  = m_locked;
        for (int n = 0; n < 4; n++) begin
            if (rst) begin
                nxt[n] = 0; sync_run[n] = 0; err_run[n] = 0; loss_m[n] = 0;
            end else begin
                if (force_v[n]) begin
                    nxt[n] = 0; sync_run[n] = 0; err_run[n] = 0;
                end else if (!prev[n]) begin
                    if (sync_v[n] && !err_v[n]) begin
                        sync_run[n]++;
                        if (sync_run[n] == LOCK) begin nxt[n] = 1; sync_run[n] = 0; end
                    end else sync_run[n] = 0;
                end else begin
                    if (err_v[n]) begin
                        err_run[n]++;
                        if (err_run[n] == UNLOCK) begin nxt[n] = 0; err_run[n] = 0; end
                    end else err_run[n] = 0;
                end
                if (STATS) begin
                    if (clr) loss_m[n] = 0;
                    else if (prev[n] && !nxt[n] && loss_m[n] < 255) loss_m[n]++;
                end
            end
            m_loss[n*8 +: 8] = 8'(loss_m[n]);
        end
        m_chg    = rst ? 4'h0 : (nxt ^ prev);
        m_all    = rst ? 1'b0 : (&nxt);
        m_locked = nxt;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin sync_run[n] = 0; err_run[n] = 0; loss_m[n] = 0; end
        forever begin
            @(posedge clk);
            model_step();
            started = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("locked_o", {28'h0, locked}, {28'h0, m_locked});
                check("all_locked_o", {31'h0, all_locked}, {31'h0, m_all});
                check("lock_chg_o", {28'h0, chg}, {28'h0, m_chg});
                check("loss_cnt_o", loss, m_loss);
            end
        end
    end

    task automatic step(input logic [3:0] s, input logic [3:0] e, input logic [3:0] f);
        sync_v = s; err_v = e; force_v = f;
        @(posedge clk);
        #1;
    endtask

    task automatic lose_lane0(input int times);
        for (int k = 0; k < times; k++) begin
            repeat (LOCK) step(4'h1, 4'h0, 4'h0);
            step(4'h0, 4'h0, 4'h1);
        end
    endtask

    initial begin
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        check("reset_locked", {28'h0, locked}, 32'h0);
        check("reset_all", {31'h0, all_locked}, 32'h0);
        check("reset_loss", loss, 32'h0);
        rst = 1'b0;

        // Lock-up of all lanes
        repeat (7) step(4'hF, 4'h0, 4'h0);
        check("lockup_7", {28'h0, locked}, 32'h0);
        step(4'hF, 4'h0, 4'h0);
        check("lockup_8_locked", {28'h0, locked}, 32'hF);
        check("lockup_8_all", {31'h0, all_locked}, 32'h1);
        check("lockup_8_chg", {28'h0, chg}, 32'hF);
        step(4'h0, 4'h0, 4'h0);
        check("lockup_chg_once", {28'h0, chg}, 32'h0);

        // Error tolerance on lane 2
        step(4'h0, 4'h4, 4'h0); step(4'h0, 4'h4, 4'h0); step(4'h0, 4'h4, 4'h0);
        step(4'h0, 4'h0, 4'h0);
        step(4'h0, 4'h4, 4'h0); step(4'h0, 4'h4, 4'h0); step(4'h0, 4'h4, 4'h0);
        check("err_tolerate", {28'h0, locked}, 32'hF);
        step(4'h0, 4'h0, 4'h0);
        repeat (3) step(4'h0, 4'h4, 4'h0);
        check("err_3_in_loss", {28'h0, locked}, 32'hF);
        step(4'h0, 4'h4, 4'h0);
        check("unlock_locked", {28'h0, locked}, 32'hB);
        check("unlock_chg", {28'h0, chg}, 32'h4);
        check("unlock_all", {31'h0, all_locked}, 32'h0);

        // Relock lane 2, then reset with every lane locked
        repeat (LOCK) step(4'hF, 4'h0, 4'h0);
        check("relock_all", {31'h0, all_locked}, 32'h1);
        rst = 1'b1;
        step(4'hF, 4'h0, 4'h0);
        check("rst_locked", {28'h0, locked}, 32'h0);
        check("rst_all", {31'h0, all_locked}, 32'h0);
        check("rst_chg", {28'h0, chg}, 32'h0);
        rst = 1'b0;

        // Broken confirm on lane 0, sync+err collision on lane 1
        repeat (7) step(4'h3, 4'h2, 4'h0);
        check("confirm_first_run", {28'h0, locked}, 32'h0);
        step(4'h0, 4'h2, 4'h0);
        repeat (7) step(4'h3, 4'h2, 4'h0);
        check("confirm_second_7", {28'h0, locked}, 32'h0);
        step(4'h3, 4'h2, 4'h0);
        check("confirm_second_8", {28'h0, locked}, 32'h1);

        // Force hunt on lane 3 in CONFIRM with cnt=5
        repeat (5) step(4'h8, 4'h0, 4'h0);
        step(4'h8, 4'h0, 4'h8);
        repeat (7) step(4'h8, 4'h0, 4'h0);
        check("force_7_fresh", {28'h0, locked}, 32'h1);
        step(4'h8, 4'h0, 4'h0);
        check("force_8_fresh", {28'h0, locked}, 32'h9);

        // Loss statistics on lane 0 (lane 0 is locked here)
        step(4'h0, 4'h0, 4'h1);
        lose_lane0(2);
        check("loss_3", {24'h0, loss[7:0]}, STATS ? 32'd3 : 32'd0);
        lose_lane0(297);
        check("loss_sat", {24'h0, loss[7:0]}, STATS ? 32'd255 : 32'd0);
        repeat (LOCK) step(4'h1, 4'h0, 4'h0);
        clr = 1'b1;
        step(4'h0, 4'h0, 4'h1);
        clr = 1'b0;
        check("clr_wins", {24'h0, loss[7:0]}, 32'd0);
        lose_lane0(1);
        check("loss_after_clr", {24'h0, loss[7:0]}, STATS ? 32'd1 : 32'd0);
        clr = 1'b1;
        step(4'h0, 4'h0, 4'h0);
        clr = 1'b0;
        check("clr", loss, 32'h0);
        step(4'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
